// File: rtl/ula_seq_pkg.sv
// Shared opcode codes, sequencer state encodings and the double-dabble step
// used by the ALU front-end sequencer.
package ula_seq_pkg;

    localparam logic [3:0] ULA_ADD  = 4'd0;
    localparam logic [3:0] ULA_SUB  = 4'd1;
    localparam logic [3:0] ULA_MULT = 4'd2;
    localparam logic [3:0] ULA_DIV  = 4'd3;
    localparam logic [3:0] ULA_AND  = 4'd4;
    localparam logic [3:0] ULA_OR   = 4'd5;
    localparam logic [3:0] ULA_XOR  = 4'd6;
    localparam logic [3:0] ULA_NOT  = 4'd7;

    localparam logic [3:0] ULA_OPC_MAX = 4'd7;

    localparam int BCD_ITERS = 8;

    typedef enum logic [2:0] {
        S_OP1  = 3'd0,
        S_OP2  = 3'd1,
        S_OPC  = 3'd2,
        S_EXEC = 3'd3,
        S_CAPT = 3'd4,
        S_BCD  = 3'd5,
        S_SHOW = 3'd6
    } state_t;

    // One double-dabble iteration on {hundreds,tens,units,binary}:
    // correct every BCD nibble >= 5, then shift the whole register left.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5) begin
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/ula_seq_bin2bcd.sv
// Iterative 8-bit binary to 3-digit BCD converter (one dabble step per cycle).
module bin2bcd_seq
    import ula_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        done_pulse
);

    logic [19:0] shreg;
    logic [19:0] shreg_next;
    logic [2:0]  iter;

    assign shreg_next = dabble_step(shreg);
    assign done_pulse = busy && (iter == 3'(BCD_ITERS - 1));

    // The converted digits are presented during the final iteration so the
    // consumer can latch them on the same edge that ends the conversion.
    assign bcd = shreg_next[19:8];

    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg <= '0;
            iter  <= '0;
            busy  <= 1'b0;
        end else if (busy) begin
            shreg <= shreg_next;
            iter  <= iter + 3'd1;
            if (done_pulse) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            shreg <= {12'b0, bin};
            iter  <= '0;
            busy  <= 1'b1;
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Button-driven sequencer that feeds operands/opcode to the 4-bit ALU,
// captures its result and converts it to BCD for the display.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        grab,
    input  logic [3:0]  sw,
    input  logic [7:0]  ula_result,
    output logic [3:0]  ula_op1,
    output logic [3:0]  ula_op2,
    output logic [3:0]  ula_opcode,
    output logic [7:0]  result,
    output logic [11:0] bcd,
    output logic        done,
    output logic        err,
    output logic [2:0]  stage
);

    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

    state_t      state;
    logic        grab_q;
    logic        grab_rise;
    logic [3:0]  settle_cnt;
    logic        capt_err;
    logic        conv_start;
    logic        conv_busy;
    logic        conv_done;
    logic [11:0] conv_bcd;

    assign grab_rise  = grab & ~grab_q;
    assign capt_err   = (ula_opcode > ULA_OPC_MAX) ||
                        ((ula_opcode == ULA_DIV) && (ula_op2 == 4'd0));
    assign conv_start = (state == S_CAPT) && !capt_err && !conv_busy;
    assign stage      = state;

    bin2bcd_seq u_bin2bcd (
        .clock      (clock),
        .reset      (reset),
        .start      (conv_start),
        .bin        (ula_result),
        .busy       (conv_busy),
        .bcd        (conv_bcd),
        .done_pulse (conv_done)
    );

    // grab_q resets high so a button held across reset release is not an edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_OP1;
            grab_q     <= 1'b1;
            settle_cnt <= '0;
            ula_op1    <= '0;
            ula_op2    <= '0;
            ula_opcode <= '0;
            result     <= '0;
            bcd        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            grab_q <= grab;
            case (state)
                S_OP1: begin
                    if (grab_rise) begin
                        ula_op1 <= sw;
                        state   <= S_OP2;
                    end
                end
                S_OP2: begin
                    if (grab_rise) begin
                        ula_op2 <= sw;
                        state   <= S_OPC;
                    end
                end
                S_OPC: begin
                    if (grab_rise) begin
                        ula_opcode <= sw;
                        settle_cnt <= '0;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (settle_cnt == SETTLE_LIM) begin
                        state <= S_CAPT;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_CAPT: begin
                    if (capt_err) begin
                        err    <= 1'b1;
                        result <= '0;
                        bcd    <= 12'h000;
                        done   <= 1'b1;
                        state  <= S_SHOW;
                    end else if (!conv_busy) begin
                        result <= ula_result;
                        state  <= S_BCD;
                    end
                end
                S_BCD: begin
                    if (conv_done) begin
                        bcd   <= conv_bcd;
                        done  <= 1'b1;
                        state <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (grab_rise) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        state <= S_OP1;
                    end
                end
                default: begin
                    state <= S_OP1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: table of ALU transactions plus hand-written
// sequences for held buttons, ignored presses, mid-conversion reset and settle time.
module tb_ula_seq;

    logic        clock;
    logic        reset, reset4;
    logic        grab, grab4;
    logic [3:0]  sw, sw4;
    logic [7:0]  ula_result, ula_result4;
    logic [3:0]  ula_op1, ula_op2, ula_opcode;
    logic [3:0]  ula_op14, ula_op24, ula_opcode4;
    logic [7:0]  result, result4;
    logic [11:0] bcd, bcd4;
    logic        done, done4, err, err4;
    logic [2:0]  stage, stage4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op1;
        logic [3:0]  op2;
        logic [3:0]  opc;
        logic [7:0]  res;
        logic [11:0] bcdv;
        logic        errv;
        int          lat;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    ula_seq #(.SETTLE_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .grab(grab), .sw(sw), .ula_result(ula_result),
        .ula_op1(ula_op1), .ula_op2(ula_op2), .ula_opcode(ula_opcode),
        .result(result), .bcd(bcd), .done(done), .err(err), .stage(stage)
    );

    ula_seq #(.SETTLE_CYCLES(4)) dut4 (
        .clock(clock), .reset(reset4), .grab(grab4), .sw(sw4), .ula_result(ula_result4),
        .ula_op1(ula_op14), .ula_op2(ula_op24), .ula_opcode(ula_opcode4),
        .result(result4), .bcd(bcd4), .done(done4), .err(err4), .stage(stage4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU; illegal opcodes and divide-by-zero return junk that
    // the sequencer must not pass through.
    function automatic logic [7:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] op);
        logic [7:0] ea, eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (op)
            4'd0: return ea + eb;
            4'd1: return ea - eb;
            4'd2: return ea * eb;
            4'd3: return (b == 4'd0) ? 8'hEE : ea / eb;
            4'd4: return ea & eb;
            4'd5: return ea | eb;
            4'd6: return ea ^ eb;
            4'd7: return {4'b0, ~a};
            default: return 8'hFF;
        endcase
    endfunction

    always_comb ula_result  = aluModel(ula_op1, ula_op2, ula_opcode);
    always_comb ula_result4 = aluModel(ula_op14, ula_op24, ula_opcode4);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One button press: grab high across exactly one rising edge; returns at
    // the falling edge right after that edge.
    task automatic applyStimulus(input bit which, input logic [3:0] v);
        @(negedge clock);
        if (which) begin
            sw4   = v;
            grab4 = 1'b1;
        end else begin
            sw   = v;
            grab = 1'b1;
        end
        @(negedge clock);
        grab  = 1'b0;
        grab4 = 1'b0;
    endtask

    task automatic waitDone(input bit which, input int lat, input string tag);
        repeat (lat - 1) @(negedge clock);
        checkOutput({tag, "_done_early"}, which ? done4 : done, 1'b0);
        @(negedge clock);
        checkOutput({tag, "_done"}, which ? done4 : done, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{4'd7,  4'd8,  4'd0,  8'd15,  12'h015, 1'b0, 11};
        vecs[1]  = '{4'd15, 4'd15, 4'd2,  8'd225, 12'h225, 1'b0, 11};
        vecs[2]  = '{4'd3,  4'd5,  4'd1,  8'd254, 12'h254, 1'b0, 11};
        vecs[3]  = '{4'd9,  4'd0,  4'd3,  8'd0,   12'h000, 1'b1, 3};
        vecs[4]  = '{4'd4,  4'd2,  4'd12, 8'd0,   12'h000, 1'b1, 3};
        vecs[5]  = '{4'd13, 4'd4,  4'd3,  8'd3,   12'h003, 1'b0, 11};
        vecs[6]  = '{4'd9,  4'd0,  4'd7,  8'd6,   12'h006, 1'b0, 11};
        vecs[7]  = '{4'd12, 4'd10, 4'd4,  8'd8,   12'h008, 1'b0, 11};
        vecs[8]  = '{4'd12, 4'd10, 4'd5,  8'd14,  12'h014, 1'b0, 11};
        vecs[9]  = '{4'd9,  4'd9,  4'd0,  8'd18,  12'h018, 1'b0, 11};
        vecs[10] = '{4'd15, 4'd14, 4'd2,  8'd210, 12'h210, 1'b0, 11};
        vecs[11] = '{4'd4,  4'd2,  4'd15, 8'd0,   12'h000, 1'b1, 3};

        reset  = 1'b0;
        reset4 = 1'b0;
        grab   = 1'b0;
        grab4  = 1'b0;
        sw     = '0;
        sw4    = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst_stage",  stage,   3'd0);
        checkOutput("rst_done",   done,    1'b0);
        checkOutput("rst_err",    err,     1'b0);
        checkOutput("rst_result", result,  8'd0);
        checkOutput("rst_bcd",    bcd,     12'h000);
        checkOutput("rst_op1",    ula_op1, 4'd0);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b0, vecs[i].op1);
            applyStimulus(1'b0, vecs[i].op2);
            applyStimulus(1'b0, vecs[i].opc);
            waitDone(1'b0, vecs[i].lat, $sformatf("v%0d", i));
            checkOutput($sformatf("v%0d_result", i), result, vecs[i].res);
            checkOutput($sformatf("v%0d_bcd", i),    bcd,    vecs[i].bcdv);
            checkOutput($sformatf("v%0d_err", i),    err,    vecs[i].errv);
            checkOutput($sformatf("v%0d_stage", i),  stage,  3'd6);
            checkOutput($sformatf("v%0d_opc", i),    ula_opcode, vecs[i].opc);
            applyStimulus(1'b0, 4'd0);
            checkOutput($sformatf("v%0d_ack_stage", i), stage, 3'd0);
            checkOutput($sformatf("v%0d_ack_done", i),  done,  1'b0);
            checkOutput($sformatf("v%0d_ack_err", i),   err,   1'b0);
        end

        // Held button: one capture only, even though sw changes mid-hold.
        @(negedge clock);
        sw   = 4'd5;
        grab = 1'b1;
        @(negedge clock);
        sw = 4'd9;
        repeat (19) @(negedge clock);
        grab = 1'b0;
        checkOutput("hold_stage", stage,   3'd1);
        checkOutput("hold_op1",   ula_op1, 4'd5);

        // Presses while converting are dropped.
        applyStimulus(1'b0, 4'd6);
        applyStimulus(1'b0, 4'd0);
        @(negedge clock);
        checkOutput("seq_exec", stage, 3'd3);
        @(negedge clock);
        checkOutput("seq_capt", stage, 3'd4);
        @(negedge clock);
        checkOutput("seq_bcd", stage, 3'd5);
        grab = 1'b1;
        @(negedge clock);
        grab = 1'b0;
        @(negedge clock);
        grab = 1'b1;
        @(negedge clock);
        grab = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("ign_done_early", done,  1'b0);
        checkOutput("ign_stage_bcd",  stage, 3'd5);
        @(negedge clock);
        checkOutput("ign_done",   done,   1'b1);
        checkOutput("ign_stage",  stage,  3'd6);
        checkOutput("ign_result", result, 8'd11);
        checkOutput("ign_bcd",    bcd,    12'h011);
        applyStimulus(1'b0, 4'd0);

        // Reset in the 4th conversion cycle with grab held through release.
        applyStimulus(1'b0, 4'd9);
        applyStimulus(1'b0, 4'd9);
        applyStimulus(1'b0, 4'd0);
        repeat (6) @(negedge clock);
        reset = 1'b0;
        grab  = 1'b1;
        sw    = 4'd5;
        @(negedge clock);
        checkOutput("mrst_stage",  stage,      3'd0);
        checkOutput("mrst_done",   done,       1'b0);
        checkOutput("mrst_err",    err,        1'b0);
        checkOutput("mrst_result", result,     8'd0);
        checkOutput("mrst_bcd",    bcd,        12'h000);
        checkOutput("mrst_op1",    ula_op1,    4'd0);
        checkOutput("mrst_op2",    ula_op2,    4'd0);
        checkOutput("mrst_opc",    ula_opcode, 4'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("mrst_held_stage", stage,   3'd0);
        checkOutput("mrst_held_op1",   ula_op1, 4'd0);
        grab = 1'b0;
        applyStimulus(1'b0, 4'd6);
        applyStimulus(1'b0, 4'd7);
        applyStimulus(1'b0, 4'd0);
        waitDone(1'b0, 11, "post_rst");
        checkOutput("post_rst_result", result, 8'd13);
        checkOutput("post_rst_bcd",    bcd,    12'h013);

        // Longer settle time on the second instance.
        @(negedge clock);
        reset4 = 1'b1;
        applyStimulus(1'b1, 4'd2);
        applyStimulus(1'b1, 4'd3);
        applyStimulus(1'b1, 4'd6);
        waitDone(1'b1, 14, "settle4");
        checkOutput("settle4_result", result4, 8'd1);
        checkOutput("settle4_bcd",    bcd4,    12'h001);
        checkOutput("settle4_err",    err4,    1'b0);
        checkOutput("settle4_stage",  stage4,  3'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Sequencer in front of the 4-bit ALU (ula).
- Collects operand 1, operand 2 and opcode from the board switches on successive presses of the grab button.
- Drives them to the ALU and waits a configurable settle time, then captures the 8-bit result.
- Flags divide-by-zero and illegal opcodes.
- Converts the result to 3-digit BCD with an iterative double-dabble for the 7-segment display path.

Parameters:
SETTLE_CYCLES, 1, cycles spent in S_EXEC before capturing the ALU result (legal 1..15)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clock
grab  input  1  grab button level, active-high, already synchronised; internally edge-detected
sw  input  4  switch value captured as op1/op2/opcode
ula_result  input  8  result from ALU
ula_op1  output  4  registered operand 1 to ALU
ula_op2  output  4  registered operand 2 to ALU
ula_opcode  output  4  registered opcode to ALU
result  output  8  captured binary result
bcd  output  12  {hundreds,tens,units} BCD of result
done  output  1  high while result/bcd valid (S_SHOW)
err  output  1  high in S_SHOW when opcode illegal (>7) or DIV with op2==0
stage  output  3  current state encoding, for LEDs

Behaviour:
- Reset (reset==0 at a clock edge), from any state including mid-BCD:
  - state<=S_OP1.
  - ula_op1, ula_op2, ula_opcode, result, bcd, done, err, BCD counter all <=0.
  - grab_q<=1, so a button held through reset produces no edge.
- grab_rise = grab & ~grab_q; grab_q<=grab every cycle. One rise = one action; a held button is ignored after its first cycle.
- Opcodes (unsigned 4-bit): ADD=0, SUB=1, MULT=2, DIV=3, AND=4, OR=5, XOR=6, NOT=7; 8..15 illegal.
- States (stage value):
  - S_OP1(0): on grab_rise ula_op1<=sw -> S_OP2.
  - S_OP2(1): on grab_rise ula_op2<=sw -> S_OPC.
  - S_OPC(2): on grab_rise ula_opcode<=sw, settle counter<=0 -> S_EXEC.
  - S_EXEC(3): counter increments; after SETTLE_CYCLES cycles -> S_CAPT.
  - S_CAPT(4):
    - Illegal opcode, or opcode==DIV with ula_op2==0: err<=1, result<=0, bcd<=12'h000 -> S_SHOW.
    - Otherwise: result<=ula_result, load shift reg {12'b0,ula_result}, iteration count<=0 -> S_BCD.
  - S_BCD(5): each cycle, add 3 to every BCD nibble >=5, then shift left 1. After 8 iterations bcd<=upper 12 bits -> S_SHOW.
  - S_SHOW(6): done=1. On grab_rise, done<=0 and err<=0 -> S_OP1. result/bcd hold until the next S_CAPT.
- grab_rise is ignored in S_EXEC, S_CAPT and S_BCD; no queuing.
- Latency: opcode grab_rise sampled at edge t -> done first high in the cycle after edge t+SETTLE_CYCLES+10. Default SETTLE_CYCLES=1 gives 11 cycles.
- Arithmetic:
  - ALU result is treated as unsigned 8-bit; max product 15*15=225 fits.
  - SUB underflow wraps mod 256 (3-5 -> 254) and is not an error.
  - NOT ignores op2 but op2 is still entered.
- ula_op*/ula_opcode stay stable from S_OPC exit through S_SHOW.
- Reset asserted together with grab_rise: reset wins.

Decomposition:
- Shared constants header holds:
  - ULA_* opcode codes;
  - state encodings S_OP1..S_SHOW;
  - ULA_OPC_MAX=7.
- One sub-module: bin2bcd_seq.
  - Ports: clock, reset, start, bin[7:0], busy, bcd[11:0], done_pulse.
  - Implements the 8-iteration double-dabble.
  - ula_seq holds its FSM in S_BCD until done_pulse.

Test Plan:
1. Reset, then grab with sw=7, 8, ADD (0); model ALU -> result=15, bcd=12'h015, err=0, done high 11 cycles after opcode edge. Next grab -> stage=0, done=0.
2. sw=15, 15, MULT -> result=225, bcd=12'h225. sw=3, 5, SUB -> result=254, bcd=12'h254, err=0.
3. sw=9, 0, DIV -> err=1, result=0, bcd=12'h000, done high 2+SETTLE cycles after edge (no BCD phase). Opcode sw=12 -> err=1 likewise.
4. Hold grab high for 20 cycles in S_OP1 -> exactly one capture, stage=1. Grab pulses during S_BCD -> ignored, stage sequence unchanged.
5. Assert reset during the 4th S_BCD cycle -> next cycle stage=0, all outputs 0. Grab held through reset release produces no capture.
6. SETTLE_CYCLES=4, sw=2, 3, XOR -> result=1, done high 14 cycles after opcode edge.
